mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 28 ++
 rtl/mem_access_ctrl.sv | 111 +++++++++++
 tb/tb_mem_access_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Requester + memory-side bundle for mem_access_ctrl.
// slave is the controller's view; master is the requester/memory environment view.
interface mem_access_ctrl_if;
  logic        req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic [7:0]  err_count;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_data_out;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_data_out,
    output busy, ack, err, rdata, err_count, mem_address, mem_data_in, mem_rd, mem_wr
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_data_out,
    input  busy, ack, err, rdata, err_count, mem_address, mem_data_in, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding memory access controller: checks a request, issues one
// memory strobe, captures read data and returns a one-cycle ack/err pulse.
module mem_access_ctrl #(
  parameter int unsigned USER_BASE = 2048
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);
  localparam logic [31:0] USER_BASE_W = 32'(USER_BASE);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, RESP} state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        reject;

  // Writes below USER_BASE are protected; any misaligned access is refused.
  assign reject = (bus.req_addr[1:0] != 2'b00) ||
                  (bus.req_we && (bus.req_addr < USER_BASE_W));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_cnt_d = err_cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (reject) begin
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else if (bus.req_we) begin
            state_d  = WR_ISSUE;
            mem_wr_d = 1'b1;
          end else begin
            state_d  = RD_ISSUE;
            mem_rd_d = 1'b1;
          end
        end
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        // Memory registered the word at the edge that ended RD_ISSUE.
        rdata_d = bus.mem_data_out;
        state_d = RESP;
        ack_d   = 1'b1;
      end
      WR_ISSUE: begin
        state_d = RESP;
        ack_d   = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.ack         = ack_q;
  assign bus.err         = err_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.err_count   = err_cnt_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level model
// (latency, status, stored words, error counter).
module tb_mem_access_ctrl;
  localparam int unsigned UB = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_load = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.USER_BASE(UB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory environment: word array, registers read data on the mem_rd edge.
  logic [31:0] tb_mem [1024];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'(i) * 32'h9E37_79B9;
      tb_mem[525] <= 32'h0000_001E;
    end else begin
      if (bus.mem_rd) bus.mem_data_out <= tb_mem[bus.mem_address[11:2]];
      if (bus.mem_wr) tb_mem[bus.mem_address[11:2]] <= bus.mem_data_in;
    end
  end

  // Reference model state
  logic [31:0] m_mem [1024];
  logic [31:0] m_rdata;
  int          m_errcnt;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bit rej;
    int exp_lat, lat, rdc, wrc;
    logic [31:0] ma, md;
    rej     = (addr[1:0] != 2'b00) || (we && (addr < UB));
    exp_lat = rej ? 1 : (we ? 2 : 3);
    bus.req = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    lat = 0; rdc = 0; wrc = 0; ma = '0; md = '0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        // Scramble the request bus: the controller must hold its latched copy.
        bus.req = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
      end
      rdc += int'(bus.mem_rd);
      wrc += int'(bus.mem_wr);
      chk("rd_wr_excl", 32'(bus.mem_rd & bus.mem_wr), 32'd0);
      if (bus.ack) begin
        lat = i; ma = bus.mem_address; md = bus.mem_data_in;
      end
    end
    if (rej) begin
      if (m_errcnt < 255) m_errcnt++;
    end else if (we) m_mem[addr[11:2]] = wd;
    else             m_rdata = m_mem[addr[11:2]];
    chk("ack_latency", 32'(lat), 32'(exp_lat));
    chk("err", 32'(bus.err), 32'(rej));
    chk("addr_held", ma, addr);
    chk("wdata_held", md, wd);
    chk("rd_strobes", 32'(rdc), 32'((!rej && !we) ? 1 : 0));
    chk("wr_strobes", 32'(wrc), 32'((!rej && we) ? 1 : 0));
    chk("rdata", bus.rdata, m_rdata);
    chk("err_count", 32'(bus.err_count), 32'(m_errcnt));
    @(negedge clk);
    chk("ack_one_cycle", 32'({bus.ack, bus.busy}), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic we;
    int last, acks, rdc, ackacc;
    bus.req = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 1024; i++) m_mem[i] = 32'(i) * 32'h9E37_79B9;
    m_mem[525] = 32'h0000_001E;
    m_rdata = '0; m_errcnt = 0;

    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({bus.busy, bus.ack, bus.err, bus.mem_rd, bus.mem_wr}), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_errcnt", 32'(bus.err_count), 32'd0);
    chk("rst_addr", bus.mem_address, 32'd0);
    chk("rst_wdata", bus.mem_data_in, 32'd0);
    // req alongside reset must be ignored
    bus.req = 1'b1; bus.req_addr = 32'd2100;
    @(negedge clk);
    chk("rst_over_req", 32'(bus.busy), 32'd0);
    bus.req = 1'b0; rst = 1'b0; mem_load = 1'b0;
    @(negedge clk);

    // Directed cases
    do_txn(1'b0, 32'd2100, 32'h0);
    do_txn(1'b1, 32'd2120, 32'hDEAD_BEEF);
    do_txn(1'b0, 32'd2120, 32'h0);
    do_txn(1'b0, 32'd2050, 32'h0);
    do_txn(1'b1, 32'd8, 32'h1234_5678);
    do_txn(1'b0, 32'd0, 32'h0);
    do_txn(1'b1, 32'd2048, 32'hA5A5_0001);
    do_txn(1'b1, 32'd2044, 32'h5A5A_0002);

    // Held request: one read every 4 cycles, no queuing of busy-time requests
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'd2048;
    last = 0; acks = 0; rdc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      rdc += int'(bus.mem_rd);
      if (bus.ack) begin
        acks++;
        chk("hold_gap", 32'(i - last), 32'((acks == 1) ? 3 : 4));
        last = i;
      end
    end
    bus.req = 1'b0;
    m_rdata = m_mem[512];
    chk("hold_acks", 32'(acks), 32'd10);
    chk("hold_rd", 32'(rdc), 32'd10);
    chk("hold_rdata", bus.rdata, m_rdata);
    @(negedge clk);

    // Random mix
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       a = 32'(UB + 4 * $urandom_range(0, 511));
        1:       a = 32'(4 * $urandom_range(0, 511));
        default: a = 32'(4 * $urandom_range(0, 1023) + $urandom_range(1, 3));
      endcase
      d = $urandom;
      do_txn(we, a, d);
    end

    // Reset during RD_CAPTURE: no ack, state cleared
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'd2100;
    @(negedge clk); bus.req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    chk("midrst_rdata", bus.rdata, 32'd0);
    chk("midrst_errcnt", 32'(bus.err_count), 32'd0);
    rst = 1'b0; m_rdata = '0; m_errcnt = 0;
    ackacc = 0;
    repeat (4) begin @(negedge clk); ackacc |= int'(bus.ack); end
    chk("midrst_no_ack", 32'(ackacc), 32'd0);

    // Saturation of the rejection counter
    for (int n = 0; n < 300; n++)
      do_txn(1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 1023) + $urandom_range(1, 3)), $urandom);
    chk("errcnt_sat", 32'(bus.err_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
